// File: rtl/ring_reg_fifo.sv
// ring_reg_fifo: parametrised register-based first-word-fall-through FIFO.
// Latency: a write is visible on oRdDat the cycle after it is accepted; a pop shows the next entry the cycle after.
// Backpressure: a write to a full FIFO is accepted only with a same-cycle pop; optional sticky oErr when RING_REG_FIFO_ERR_EN is defined.
module ring_reg_fifo #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 4,
  parameter  int AF_MARGIN = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iWrEn,
  input  logic [WIDTH-1:0] iWrDat,
  input  logic             iRdEn,
  output logic             oFul,
  output logic             oEmpty,
  output logic             oAlmFul,
  output logic [CW-1:0]    oCnt,
  output logic [WIDTH-1:0] oRdDat,
  output logic             oErr
);

  localparam int PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Occupancy at which almost-full asserts; may be <= 0 for degenerate margins.
  localparam int AF_TH    = DEPTH - AF_MARGIN;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             rd_acc;
  logic             wr_acc;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pop needs data; a push into a full FIFO rides on a simultaneous pop.
  assign rd_acc = iRdEn && (cnt != '0);
  assign wr_acc = iWrEn && ((cnt != CW'(DEPTH)) || rd_acc);

  // Storage array: cleared on reset, written at wp on accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_acc) begin
      mem[wp] <= iWrDat;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_acc) wp <= ptr_inc(wp);
      if (rd_acc) rp <= ptr_inc(rp);
      cnt <= cnt + CW'(wr_acc) - CW'(rd_acc);
    end
  end

  // Flags are pure decodes of the registered count; head data falls through.
  assign oCnt    = cnt;
  assign oFul    = (cnt == CW'(DEPTH));
  assign oEmpty  = (cnt == '0);
  assign oAlmFul = (int'(cnt) >= AF_TH);
  assign oRdDat  = mem[rp];

`ifdef RING_REG_FIFO_ERR_EN
  logic err;

  // Sticky error: overflow (rejected write) or underflow (read while empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((iWrEn && !wr_acc) || (iRdEn && (cnt == '0))) begin
      err <= 1'b1;
    end
  end

  assign oErr = err;
`else
  assign oErr = 1'b0;
`endif

endmodule

// File: doc/ring_reg_fifo.md
# ring_reg_fifo

Parametrised register-based first-word-fall-through FIFO, the next-generation replacement for the fixed two-entry register FIFO used at PtRing router input and output ports. It generalises data width and depth, exports an occupancy count and a programmable almost-full flag for credit/backpressure generation, and accepts a write to a full FIFO when a read pops in the same cycle. An optional sticky overflow/underflow error flag is compiled in by macro.

## Interface
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of entries (>=2; need not be a power of two)
- AF_MARGIN, 1, oAlmFul asserts when free entries <= AF_MARGIN (0..DEPTH-1)
- CW, $clog2(DEPTH+1), local parameter: count width
- Reset is synchronous and active-high; the block has one clock. Clock port is clk, reset port is rst.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- iWrEn  in  1  write request
- iWrDat  in  WIDTH  write data
- iRdEn  in  1  read (pop) request
- oFul  out  1  cnt == DEPTH
- oEmpty  out  1  cnt == 0
- oAlmFul  out  1  cnt >= DEPTH-AF_MARGIN
- oCnt  out  CW  current occupancy
- oRdDat  out  WIDTH  head entry (valid when !oEmpty)
- oErr  out  1  sticky overflow/underflow flag (see Configuration)

## Operation
- Storage: DEPTH x WIDTH register array, write pointer wp, read pointer rp, counter cnt; all registered.
- Pointers increment by 1 and wrap DEPTH-1 -> 0 explicitly (no power-of-two assumption).
- Read accept rdAcc = iRdEn && cnt != 0.
- Write accept wrAcc = iWrEn && (cnt != DEPTH || rdAcc); write into full FIFO is accepted only with a simultaneous accepted pop.
- Rejected requests (write when full with no pop, read when empty) change no state.
- Next count: cnt + wrAcc - rdAcc; never exceeds DEPTH or underflows.
- Empty with iWrEn && iRdEn: write accepted, read rejected; cnt 0 -> 1. No bypass of write data to oRdDat.
- oRdDat = mem[rp] combinationally from registered state (FWFT): head data present with no read latency once stored.
- oFul, oEmpty, oAlmFul, oCnt are pure decodes of registered cnt.
- rst: wp=0, rp=0, cnt=0, all storage entries cleared to 0, oErr=0; takes precedence over simultaneous iWrEn/iRdEn. Reset mid-operation discards all contents.

## Timing
- Reset values: oFul=0, oEmpty=1, oAlmFul=(AF_MARGIN>=DEPTH ? 1 : 0) i.e. 0 for legal params, oCnt=0, oRdDat=0, oErr=0.
- Write at edge N: entry visible on oRdDat, oEmpty=0, oCnt updated in cycle following edge N (1-cycle write-to-read latency).
- Pop at edge N: next entry on oRdDat in the following cycle; back-to-back pops every cycle sustained.
- Full throughput: simultaneous accepted read+write every cycle, cnt unchanged, including at cnt==DEPTH.
- oRdDat while oEmpty=1 shows stale slot content; not checked.

## Configuration
- Macro RING_REG_FIFO_ERR_EN.
- Defined: oErr sets on edge where iWrEn && !wrAcc (overflow) or iRdEn && cnt==0 (underflow); stays 1 until rst.
- Not defined: oErr tied 0, no error logic; FIFO behaviour otherwise identical.

## Test plan
- Reset: hold rst 2 cycles with iWrEn=iRdEn=1 -> oEmpty=1, oCnt=0, oFul=0, oRdDat=0, oErr=0 after release.
- Fill (WIDTH=8, DEPTH=4, AF_MARGIN=1): write 0x01..0x04 on consecutive cycles -> oCnt 1,2,3,4; oAlmFul at cnt=3; oFul at cnt=4; oRdDat=0x01 from cycle after first write.
- Overflow: full, write 0x05 without read -> oCnt stays 4, 0x05 never read out; oErr=1 if RING_REG_FIFO_ERR_EN else 0.
- Full simultaneous: full with 0x01..0x04, write 0x05 + read -> oCnt=4; drain yields 0x02,0x03,0x04,0x05.
- Empty simultaneous: empty, write 0xA5 + read same cycle -> oCnt=1, oRdDat=0xA5; a read on empty alone sets oErr (macro on).
- Wrap/random: DEPTH=3, 1000 cycles random iWrEn/iRdEn vs reference queue model -> data order, oCnt and flags match every cycle; mid-run rst clears to empty.
